// File: rtl/bist_pkg.sv
// bist_pkg: shared state enum, March C- element table and op descriptor for the BIST sequencer
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NUM_ELEM = 6;

    // Per-element properties, bit e describes element Ee
    localparam logic [NUM_ELEM-1:0] ELEM_DOWN   = 6'b011000;
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OP = 6'b011110;
    localparam logic [NUM_ELEM-1:0] OP0_READ    = 6'b111110;
    localparam logic [NUM_ELEM-1:0] OP0_POL     = 6'b010100;

    typedef struct packed {
        logic is_read;
        logic pol;
        logic down;
        logic last_op;
    } elem_op_t;

endpackage

// File: rtl/march_elem_rom.sv
// march_elem_rom: combinational lookup of (element, op) to read/write, polarity, direction and last-op flag
module march_elem_rom
    import bist_pkg::*;
(
    input  logic [2:0] i_elem,
    input  logic       i_op,
    output elem_op_t   o_info
);

    // The second op of every two-op element is a write of the inverted background
    always_comb begin
        o_info.is_read = ~i_op & OP0_READ[i_elem];
        o_info.pol     = i_op ? ~OP0_POL[i_elem] : OP0_POL[i_elem];
        o_info.down    = ELEM_DOWN[i_elem];
        o_info.last_op = i_op | ~ELEM_TWO_OP[i_elem];
    end

endmodule

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- memory BIST sequencer with start/done/fail handshake (BIST_DIAG_EN adds fail_addr/fail_elem)
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ad_width-1:0]   mem_addr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [data_width-1:0] mem_rdata,
`ifdef BIST_DIAG_EN
    output logic [ad_width-1:0]   fail_addr,
    output logic [2:0]            fail_elem,
`endif
    output logic                  done,
    output logic                  fail
);

    state_t                r_state;
    logic [2:0]            r_elem;
    logic                  r_op;
    logic [ad_width-1:0]   r_addr;
    logic                  r_fin;
    logic [ad_width-1:0]   r_mem_addr;
    logic [data_width-1:0] r_mem_wdata;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic                  r_done;
    logic                  r_fail;
    logic                  r_vld;
    logic [data_width-1:0] r_exp;
`ifdef BIST_DIAG_EN
    logic [2:0]            r_iss_elem;
    logic [ad_width-1:0]   r_cmp_addr;
    logic [2:0]            r_cmp_elem;
    logic [ad_width-1:0]   r_fail_addr;
    logic [2:0]            r_fail_elem;
`endif

    elem_op_t   w_info;
    logic [2:0] w_next_elem;
    logic       w_addr_end;
    logic       w_mismatch;
    logic       w_issue;

    march_elem_rom u_rom (
        .i_elem (r_elem),
        .i_op   (r_op),
        .o_info (w_info)
    );

    // Element boundary, compare result and whether an op goes out this edge
    always_comb begin
        w_next_elem = r_elem + 3'd1;
        w_addr_end  = w_info.down ? (r_addr == '0) : (r_addr == '1);
        w_mismatch  = (r_state == RUN) && r_vld && (mem_rdata != r_exp);
        w_issue     = (r_state == RUN) ? !r_fin : start;
    end

    // Sequencer: issues one op per cycle, compares reads two edges later, drains after the last op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_elem      <= '0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_fin       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_vld       <= 1'b0;
            r_exp       <= '0;
`ifdef BIST_DIAG_EN
            r_iss_elem  <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
`endif
        end else begin
            r_vld <= r_mem_re;
            r_exp <= r_mem_wdata;
`ifdef BIST_DIAG_EN
            r_cmp_addr <= r_mem_addr;
            r_cmp_elem <= r_iss_elem;
`endif
            if (w_mismatch) begin
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_fail   <= 1'b1;
                r_mem_we <= 1'b0;
                r_mem_re <= 1'b0;
                r_elem   <= '0;
                r_op     <= 1'b0;
                r_addr   <= '0;
                r_fin    <= 1'b0;
`ifdef BIST_DIAG_EN
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
`endif
            end else if (r_state == RUN && r_fin) begin
                r_mem_we <= 1'b0;
                r_mem_re <= 1'b0;
                if (r_vld && !r_mem_re) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_fin   <= 1'b0;
                end
            end else if (w_issue) begin
                r_state     <= RUN;
                r_done      <= 1'b0;
                r_fail      <= 1'b0;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= {data_width{w_info.pol}};
                r_mem_we    <= ~w_info.is_read;
                r_mem_re    <= w_info.is_read;
`ifdef BIST_DIAG_EN
                r_iss_elem  <= r_elem;
                if (r_state != RUN) begin
                    r_fail_addr <= '0;
                    r_fail_elem <= '0;
                end
`endif
                if (!w_info.last_op) begin
                    r_op <= 1'b1;
                end else begin
                    r_op <= 1'b0;
                    if (!w_addr_end) begin
                        r_addr <= w_info.down ? r_addr - ad_width'(1) : r_addr + ad_width'(1);
                    end else if (r_elem == 3'(NUM_ELEM - 1)) begin
                        r_elem <= '0;
                        r_addr <= '0;
                        r_fin  <= 1'b1;
                    end else begin
                        r_elem <= w_next_elem;
                        r_addr <= ELEM_DOWN[w_next_elem] ? '1 : '0;
                    end
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign done      = r_done;
    assign fail      = r_fail;
`ifdef BIST_DIAG_EN
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
`endif

endmodule
